// File: rtl/sqrt_seq_ctrl_if.sv
// rtl/sqrt_seq_ctrl_if.sv - handshake, result and shared-adder signals of sqrt_seq_ctrl
// Optional rem_o member is present only when SQRT_SEQ_REMAINDER_EN is defined.
interface sqrt_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  localparam int ITER = WIDTH / 2;

  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] radicand_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [ITER-1:0]  root_o;
`ifdef SQRT_SEQ_REMAINDER_EN
  logic [ITER:0]    rem_o;
`endif
  logic [WIDTH-1:0] add_a_o;
  logic [WIDTH-1:0] add_b_o;
  logic             add_ci_o;
  logic [WIDTH-1:0] add_s_i;
  logic             add_co_i;

  modport slave (
`ifdef SQRT_SEQ_REMAINDER_EN
    output rem_o,
`endif
    input  in_valid_i, radicand_i, out_ready_i, add_s_i, add_co_i,
    output in_ready_o, out_valid_o, root_o, add_a_o, add_b_o, add_ci_o
  );

  modport master (
`ifdef SQRT_SEQ_REMAINDER_EN
    input  rem_o,
`endif
    output in_valid_i, radicand_i, out_ready_i, add_s_i, add_co_i,
    input  in_ready_o, out_valid_o, root_o, add_a_o, add_b_o, add_ci_o
  );
endinterface

// File: rtl/sqrt_seq_ctrl.sv
// rtl/sqrt_seq_ctrl.sv - iterative integer square root sharing one external WIDTH-bit adder
// Define SQRT_SEQ_REMAINDER_EN to expose the final remainder on rem_o.
module sqrt_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  sqrt_seq_ctrl_if.slave  bus
);
  localparam int ITER = WIDTH / 2;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rad_q;
  logic [ITER-1:0]  root_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] root_ext;
  logic [WIDTH-1:0] trial;
  logic             last_iter;

  always_comb begin
    root_ext  = WIDTH'(root_q);
    rem_sh    = {rem_q[WIDTH-3:0], rad_q[WIDTH-1:WIDTH-2]};
    trial     = {root_ext[WIDTH-3:0], 2'b01};
    last_iter = (cnt_q == CW'(ITER - 1));
  end

  // Adder operands stay at zero outside CALC so the shared adder does not toggle.
  always_comb begin
    state_d         = state_q;
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    bus.add_a_o     = '0;
    bus.add_b_o     = '0;
    bus.add_ci_o    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready_o = 1'b1;
        if (bus.in_valid_i) state_d = CALC;
      end
      CALC: begin
        bus.add_a_o  = rem_sh;
        bus.add_b_o  = ~trial;
        bus.add_ci_o = 1'b1;
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        bus.out_valid_o = 1'b1;
        if (bus.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      rad_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid_i) begin
            rad_q  <= bus.radicand_i;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
          end
        end
        CALC: begin
          // Carry-out of rem_sh + ~trial + 1 is set exactly when rem_sh >= trial.
          if (bus.add_co_i) begin
            rem_q  <= bus.add_s_i;
            root_q <= {root_q[ITER-2:0], 1'b1};
          end else begin
            rem_q  <= rem_sh;
            root_q <= {root_q[ITER-2:0], 1'b0};
          end
          rad_q <= rad_q << 2;
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.root_o = root_q;
`ifdef SQRT_SEQ_REMAINDER_EN
  assign bus.rem_o  = rem_q[ITER:0];
`endif

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// tb/tb_sqrt_seq_ctrl.sv - randomized self-checking bench for sqrt_seq_ctrl
// Drives and samples on the falling edge; reference root is a plain integer search.
module tb_sqrt_seq_ctrl;
  localparam int W  = 16;
  localparam int IT = W / 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sqrt_seq_ctrl_if #(.WIDTH(W)) bus ();

  sqrt_seq_ctrl #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Purely combinational external adder.
  assign {bus.add_co_i, bus.add_s_i} = {1'b0, bus.add_a_o} + {1'b0, bus.add_b_o}
                                     + {{W{1'b0}}, bus.add_ci_o};

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int acc_cnt = 0;
  int last_acc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.in_valid_i && bus.in_ready_o) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= cyc;
    end
  end

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Entered and left on a falling edge; the design is in IDLE (or about to be) on entry.
  task automatic run_one(input logic [W-1:0] r, input int stall, input int gap,
                         input bit hold_next, input logic [W-1:0] nxt);
    int  exp_root;
    int  n;
    int  lat;
    bit  acc;
    bit  calc_bad;
    exp_root = isqrt(int'(r));
    bus.out_ready_i = 1'b0;
    if (gap > 0) begin
      bus.in_valid_i = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.in_valid_i = 1'b1;
    bus.radicand_i = r;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      acc = bus.in_ready_o;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout rad=%0d got in_ready=%0b want 1", r, bus.in_ready_o);
      bus.in_valid_i = 1'b0;
      return;
    end
    if (hold_next) bus.radicand_i = nxt;
    else           bus.in_valid_i = 1'b0;

    lat      = 0;
    calc_bad = 1'b0;
    while (!bus.out_valid_o && lat < 50) begin
      if (bus.in_ready_o !== 1'b0 || bus.add_ci_o !== 1'b1) calc_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (calc_bad) begin
      errors++;
      $display("FAIL calc_ports rad=%0d got in_ready/ci bad want in_ready=0 ci=1", r);
    end
    checks++;
    if (lat !== IT) begin
      errors++;
      $display("FAIL latency rad=%0d got %0d want %0d", r, lat, IT);
    end
    checks++;
    if (int'(bus.root_o) !== exp_root) begin
      errors++;
      $display("FAIL root rad=%0d got %0d want %0d", r, bus.root_o, exp_root);
    end
`ifdef SQRT_SEQ_REMAINDER_EN
    checks++;
    if (int'(bus.rem_o) !== int'(r) - exp_root * exp_root) begin
      errors++;
      $display("FAIL rem rad=%0d got %0d want %0d", r, bus.rem_o, int'(r) - exp_root * exp_root);
    end
`endif
    checks++;
    if (bus.add_a_o !== '0 || bus.add_b_o !== '0 || bus.add_ci_o !== 1'b0 || bus.in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL done_ports rad=%0d got a=%h b=%h ci=%0b rdy=%0b want all 0",
               r, bus.add_a_o, bus.add_b_o, bus.add_ci_o, bus.in_ready_o);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid_o !== 1'b1 || int'(bus.root_o) !== exp_root) begin
        errors++;
        $display("FAIL stall_hold rad=%0d got valid=%0b root=%0d want 1/%0d",
                 r, bus.out_valid_o, bus.root_o, exp_root);
      end
    end
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 ||
        bus.add_a_o !== '0 || bus.add_b_o !== '0 || bus.add_ci_o !== 1'b0) begin
      errors++;
      $display("FAIL release rad=%0d got valid=%0b rdy=%0b a=%h b=%h ci=%0b want 0/1/0/0/0",
               r, bus.out_valid_o, bus.in_ready_o, bus.add_a_o, bus.add_b_o, bus.add_ci_o);
    end
  endtask

  task automatic test_reset();
    bus.in_valid_i  = 1'b0;
    bus.radicand_i  = '0;
    bus.out_ready_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.root_o !== '0) begin
      errors++;
      $display("FAIL reset_out got valid=%0b root=%0d want 0/0", bus.out_valid_o, bus.root_o);
    end
    checks++;
    if (bus.add_a_o !== '0 || bus.add_b_o !== '0 || bus.add_ci_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_adder got a=%h b=%h ci=%0b want 0", bus.add_a_o, bus.add_b_o, bus.add_ci_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %0b want 1", bus.in_ready_o);
    end
  endtask

  task automatic test_basic();
    run_one(16'd144, 0, 0, 1'b0, '0);
  endtask

  task automatic test_small();
    logic [W-1:0] vals [4];
    vals = '{16'd0, 16'd1, 16'd2, 16'd15};
    foreach (vals[i]) run_one(vals[i], 0, 0, 1'b0, '0);
  endtask

  task automatic test_max();
    run_one(16'hFFFF, 0, 1, 1'b0, '0);
  endtask

  task automatic test_backpressure();
    run_one(16'd1000, 5, 0, 1'b0, '0);
    run_one(16'd4, 0, 0, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    bus.in_valid_i = 1'b1;
    bus.radicand_i = 16'd50000;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.root_o !== '0 ||
        bus.add_a_o !== '0 || bus.add_b_o !== '0 || bus.add_ci_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got valid=%0b root=%0d a=%h b=%h ci=%0b want all 0",
               bus.out_valid_o, bus.root_o, bus.add_a_o, bus.add_b_o, bus.add_ci_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_one(16'd49, 0, 0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    int a0;
    run_one(16'd12345, 0, 0, 1'b0, '0);
    a0 = last_acc;
    run_one(16'd54321, 0, 0, 1'b0, '0);
    checks++;
    if (last_acc - a0 !== IT + 2) begin
      errors++;
      $display("FAIL throughput got %0d want %0d", last_acc - a0, IT + 2);
    end
  endtask

  task automatic test_random();
    int           snap;
    logic [W-1:0] cur;
    logic [W-1:0] nxt;
    bit           hold;
    snap = acc_cnt;
    cur  = W'($urandom_range(0, 65535));
    hold = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      int gap;
      nxt  = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255) ** 2)
                                         : W'($urandom_range(0, 65535));
      gap  = hold ? 0 : $urandom_range(0, 2);
      hold = (i < 1999) && ($urandom_range(0, 1) == 1);
      run_one(cur, $urandom_range(0, 3), gap, hold, nxt);
      cur = nxt;
    end
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (acc_cnt - snap !== 2000) begin
      errors++;
      $display("FAIL accept_count got %0d want 2000", acc_cnt - snap);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_small();
    test_max();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
